// File: rtl/spi_3w_responder.sv
// ============================================================================
//  Module   : spi_3w_responder
//  Purpose  : 3-wire SPI target emulating a converter register port
//             (16-bit instruction, 8-bit data, streaming) backed by a
//             byte-wide register file with a host read/preload port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_3w_responder #(
    parameter int REG_DEPTH   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         axil_aclk,
    input  logic                         axil_aresetn,
    input  logic                         spi_csb,
    input  logic                         spi_sclk,
    input  logic                         spi_sdio_i,
    output logic                         spi_sdio_o,
    output logic                         spi_sdio_t,
    input  logic                         host_we,
    input  logic [$clog2(REG_DEPTH)-1:0] host_addr,
    input  logic [7:0]                   host_wdata,
    output logic [7:0]                   host_rdata,
    output logic                         wr_valid,
    output logic [14:0]                  wr_addr,
    output logic [7:0]                   wr_data,
    output logic                         busy
);

    localparam int AW = $clog2(REG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdio_sync;
    logic                   csb_prev;
    logic                   sclk_prev;
    logic                   csb_s;
    logic                   sclk_s;
    logic                   sdio_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   csb_fall;
    logic                   csb_rise;

    logic [3:0]             bit_cnt;
    logic [14:0]            shreg;
    logic [14:0]            addr;
    logic [7:0]             tx;
    logic [1:0]             load_pipe;
    logic [7:0]             rd_q;
    logic [15:0]            instr_word;
    logic [7:0]             byte_in;
    logic                   spi_we;
    logic [AW-1:0]          spi_waddr;

    logic [7:0]             mem [REG_DEPTH];

    assign csb_s      = csb_sync[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign sdio_s     = sdio_sync[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign sclk_fall  = ~sclk_s & sclk_prev;
    assign csb_fall   = ~csb_s & csb_prev;
    assign csb_rise   = csb_s & ~csb_prev;

    assign instr_word = {shreg, sdio_s};
    assign byte_in    = {shreg[6:0], sdio_s};
    assign spi_waddr  = addr[AW-1:0];
    // A write byte commits on its 8th rise unless CSB is going away in the same cycle.
    assign spi_we     = axil_aresetn && (state == ST_WDATA) && sclk_rise &&
                        (bit_cnt == 4'd7) && !csb_rise;

    // Pad synchronizers and edge-detect history. CSB resets low so that a CSB
    // already low at reset release never looks like a fresh falling edge.
    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            csb_sync  <= '0;
            sclk_sync <= '0;
            sdio_sync <= '0;
            csb_prev  <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], spi_sdio_i};
            csb_prev  <= csb_s;
            sclk_prev <= sclk_s;
        end
    end

    // Register file writes; an SPI write to the same location beats the host.
    always_ff @(posedge axil_aclk) begin
        if (spi_we) begin
            mem[spi_waddr] <= byte_in;
        end
        if (host_we && !(spi_we && (host_addr == spi_waddr))) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // SPI-side read port; always tracks the current transfer address.
    always_ff @(posedge axil_aclk) begin
        rd_q <= mem[spi_waddr];
    end

    // Host read port, write-first so same-cycle writes are visible next cycle.
    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            host_rdata <= 8'h00;
        end else if (spi_we && (spi_waddr == host_addr)) begin
            host_rdata <= byte_in;
        end else if (host_we) begin
            host_rdata <= host_wdata;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

    // Transaction FSM with registered SDIO, write-strobe and busy outputs.
    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 15'd0;
            addr       <= 15'd0;
            tx         <= 8'h00;
            load_pipe  <= 2'b00;
            spi_sdio_o <= 1'b0;
            spi_sdio_t <= 1'b1;
            wr_valid   <= 1'b0;
            wr_addr    <= 15'd0;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            // Prefetch: address settles, then rd_q, then the byte lands in tx.
            load_pipe <= {load_pipe[0], 1'b0};
            if (load_pipe[1]) begin
                tx <= rd_q;
            end
            if (csb_rise) begin
                state      <= ST_IDLE;
                bit_cnt    <= 4'd0;
                spi_sdio_t <= 1'b1;
                spi_sdio_o <= 1'b0;
                busy       <= 1'b0;
                load_pipe  <= 2'b00;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csb_fall) begin
                            state   <= ST_INSTR;
                            bit_cnt <= 4'd0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_INSTR: begin
                        if (sclk_rise) begin
                            shreg   <= {shreg[13:0], sdio_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                addr    <= instr_word[14:0];
                                bit_cnt <= 4'd0;
                                if (instr_word[15]) begin
                                    state     <= ST_RDATA;
                                    load_pipe <= 2'b01;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            shreg   <= {shreg[13:0], sdio_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt  <= 4'd0;
                                wr_valid <= 1'b1;
                                wr_addr  <= addr;
                                wr_data  <= byte_in;
                                addr     <= addr + 15'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_fall) begin
                            spi_sdio_o <= tx[7];
                            tx         <= {tx[6:0], 1'b0};
                            spi_sdio_t <= 1'b0;
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= 4'd0;
                                addr      <= addr + 15'd1;
                                load_pipe <= 2'b01;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_3w_responder.sv
// ============================================================================
//  Module   : tb_spi_3w_responder
//  Purpose  : Self-checking bench for spi_3w_responder: vector table,
//             randomized transactions against a register-file model, and
//             hand-written corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_3w_responder;

    localparam int REG_DEPTH   = 64;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic        clk        = 1'b0;
    logic        rstn       = 1'b0;
    logic        csb        = 1'b1;
    logic        sclk       = 1'b0;
    logic        sdio_i     = 1'b0;
    logic        host_we    = 1'b0;
    logic [5:0]  host_addr  = 6'd0;
    logic [7:0]  host_wdata = 8'h00;
    logic        sdio_o;
    logic        sdio_t;
    logic [7:0]  host_rdata;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [REG_DEPTH];
    logic [22:0] exp_q [$];
    logic [22:0] obs_q [$];

    typedef struct {
        logic [14:0] waddr;
        logic [7:0]  wdata;
        logic [14:0] raddr;
        logic [7:0]  exp;
    } vec_t;

    spi_3w_responder #(
        .REG_DEPTH   (REG_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .axil_aclk    (clk),
        .axil_aresetn (rstn),
        .spi_csb      (csb),
        .spi_sclk     (sclk),
        .spi_sdio_i   (sdio_i),
        .spi_sdio_o   (sdio_o),
        .spi_sdio_t   (sdio_t),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Collect every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_valid) obs_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #950us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic mosi, output logic miso, output logic t_at_rise);
        sdio_i = mosi;
        tick(HALF);
        sclk      = 1'b1;
        miso      = sdio_o;
        t_at_rise = sdio_t;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick(1);
        host_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic host_check(input string name, input logic [5:0] a, input logic [7:0] req);
        host_addr = a;
        tick(1);
        check(name, {24'd0, host_rdata}, {24'd0, req});
    endtask

    task automatic spi_write(input logic [14:0] a, input int n, input logic [7:0] d [4]);
        logic        m;
        logic        t;
        logic [15:0] ins;
        logic [14:0] ea;
        ins = {1'b0, a};
        csb = 1'b0;
        tick(HALF);
        for (int i = 15; i >= 0; i--) spi_bit(ins[i], m, t);
        for (int b = 0; b < n; b++)
            for (int i = 7; i >= 0; i--) spi_bit(d[b][i], m, t);
        tick(HALF);
        csb = 1'b1;
        tick(2 * HALF);
        for (int b = 0; b < n; b++) begin
            ea = a + 15'(b);
            model_mem[(int'(a) + b) % REG_DEPTH] = d[b];
            exp_q.push_back({ea, d[b]});
        end
    endtask

    task automatic spi_read(input logic [14:0] a, input int n, output logic [7:0] q [4],
                            output logic turn_ok);
        logic        m;
        logic        t;
        logic [15:0] ins;
        ins     = {1'b1, a};
        turn_ok = 1'b1;
        for (int b = 0; b < 4; b++) q[b] = 8'h00;
        csb = 1'b0;
        tick(HALF);
        for (int i = 15; i >= 0; i--) begin
            spi_bit(ins[i], m, t);
            if (t !== 1'b1) turn_ok = 1'b0;
        end
        for (int b = 0; b < n; b++)
            for (int i = 7; i >= 0; i--) begin
                spi_bit(1'($urandom), m, t);
                q[b][i] = m;
                if (t !== 1'b0) turn_ok = 1'b0;
            end
        tick(HALF);
        csb = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic compare_wr(input string name);
        int n;
        check(name, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(name, {9'd0, obs_q[i]}, {9'd0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t        vt [5];
        logic [7:0]  d [4];
        logic [7:0]  q [4];
        logic        tok;
        logic        m;
        logic        t;
        logic [15:0] ins;
        logic [14:0] ra;
        int          n;

        vt[0] = '{15'h0005, 8'hA5, 15'h0005, 8'hA5};
        vt[1] = '{15'h0047, 8'h3C, 15'h0007, 8'h3C};
        vt[2] = '{15'h7FFF, 8'h81, 15'h003F, 8'h81};
        vt[3] = '{15'h0000, 8'hFF, 15'h4000, 8'hFF};
        vt[4] = '{15'h1234, 8'h00, 15'h0034, 8'h00};

        // Reset state
        tick(5);
        check("rst_sdio_t", {31'd0, sdio_t}, 32'd1);
        check("rst_sdio_o", {31'd0, sdio_o}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_addr", {17'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
        rstn = 1'b1;
        tick(4);

        // Preload whole file so the model is fully defined
        for (int i = 0; i < REG_DEPTH; i++) host_write(6'(i), 8'($urandom));
        tick(2);
        check("preload_no_strobe", obs_q.size(), 0);

        // Vector table: write, then read back through SPI and host port
        for (int v = 0; v < 5; v++) begin
            d[0] = vt[v].wdata;
            spi_write(vt[v].waddr, 1, d);
            compare_wr("tbl_wr_event");
            spi_read(vt[v].raddr, 1, q, tok);
            check("tbl_spi_read", {24'd0, q[0]}, {24'd0, vt[v].exp});
            check("tbl_turnaround", {31'd0, tok}, 32'd1);
            check("tbl_sdio_t_idle", {31'd0, sdio_t}, 32'd1);
            host_check("tbl_host_read", vt[v].raddr[5:0], vt[v].exp);
        end

        // Streaming write across the end of the file, then streaming read
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        spi_write(15'h003E, 4, d);
        check("strm_n", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("strm_a0", {17'd0, obs_q[0][22:8]}, 32'h3E);
            check("strm_a3", {17'd0, obs_q[3][22:8]}, 32'h41);
        end
        compare_wr("strm_wr_event");
        host_check("strm_mem62", 6'd62, 8'h11);
        host_check("strm_mem0", 6'd0, 8'h33);
        host_check("strm_mem1", 6'd1, 8'h44);
        spi_read(15'h003E, 4, q, tok);
        check("strm_read", {q[0], q[1], q[2], q[3]}, 32'h11223344);
        check("strm_turnaround", {31'd0, tok}, 32'd1);

        // Abort after 5 data bits of a write
        host_write(6'd16, 8'h5A);
        ins = 16'h0010;
        csb = 1'b0;
        tick(HALF);
        for (int i = 15; i >= 0; i--) spi_bit(ins[i], m, t);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m, t);
        check("abort_busy_hi", {31'd0, busy}, 32'd1);
        tick(HALF);
        csb = 1'b1;
        tick(2 * HALF);
        check("abort_no_strobe", obs_q.size(), 0);
        check("abort_sdio_t", {31'd0, sdio_t}, 32'd1);
        check("abort_busy_lo", {31'd0, busy}, 32'd0);
        host_check("abort_mem", 6'd16, 8'h5A);

        // Host/SPI collision on the commit cycle of an SPI write of 0xCC to 9
        host_write(6'd9, 8'h11);
        ins = 16'h0009;
        d[0] = 8'hCC;
        csb = 1'b0;
        tick(HALF);
        for (int i = 15; i >= 0; i--) spi_bit(ins[i], m, t);
        for (int i = 7; i >= 1; i--) spi_bit(d[0][i], m, t);
        sdio_i = d[0][0];
        tick(HALF);
        sclk = 1'b1;
        tick(SYNC_STAGES);
        host_addr  = 6'd9;
        host_wdata = 8'h77;
        host_we    = 1'b1;
        tick(1);
        host_we = 1'b0;
        check("coll_host_rdata", {24'd0, host_rdata}, 32'hCC);
        tick(HALF - SYNC_STAGES - 1);
        sclk = 1'b0;
        tick(HALF);
        csb = 1'b1;
        tick(2 * HALF);
        model_mem[9] = 8'hCC;
        exp_q.push_back({15'h0009, 8'hCC});
        compare_wr("coll_wr_event");
        host_check("coll_mem", 6'd9, 8'hCC);

        // Reset during the 3rd data bit of a read
        ins = 16'h8002;
        csb = 1'b0;
        tick(HALF);
        for (int i = 15; i >= 0; i--) spi_bit(ins[i], m, t);
        for (int i = 0; i < 2; i++) spi_bit(1'b0, m, t);
        tick(HALF);
        sclk = 1'b1;
        tick(2);
        rstn = 1'b0;
        tick(3);
        check("mrst_sdio_t", {31'd0, sdio_t}, 32'd1);
        check("mrst_sdio_o", {31'd0, sdio_o}, 32'd0);
        check("mrst_wr_addr", {17'd0, wr_addr}, 32'd0);
        check("mrst_wr_data", {24'd0, wr_data}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_host_rdata", {24'd0, host_rdata}, 32'd0);
        sclk = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(4 * HALF);
        check("mrst_csb_low_ignored", {31'd0, busy}, 32'd0);
        csb = 1'b1;
        tick(2 * HALF);
        obs_q.delete();
        d[0] = 8'h6B;
        spi_write(15'h0020, 1, d);
        compare_wr("mrst_wr_event");
        spi_read(15'h0020, 1, q, tok);
        check("mrst_read", {24'd0, q[0]}, 32'h6B);
        check("mrst_turnaround", {31'd0, tok}, 32'd1);

        // Randomized transactions against the register-file model
        for (int k = 0; k < 14; k++) begin
            ra = 15'($urandom_range(0, 32767));
            if (k % 5 == 0) ra = 15'h7FFE;
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0, 1: begin
                    for (int b = 0; b < 4; b++) d[b] = 8'($urandom);
                    spi_write(ra, n, d);
                    compare_wr("rnd_wr_event");
                end
                2: begin
                    spi_read(ra, n, q, tok);
                    for (int b = 0; b < n; b++)
                        check("rnd_spi_read", {24'd0, q[b]},
                              {24'd0, model_mem[(int'(ra) + b) % REG_DEPTH]});
                    check("rnd_turnaround", {31'd0, tok}, 32'd1);
                end
                default: begin
                    host_write(ra[5:0], 8'($urandom));
                    host_check("rnd_host_read", ra[5:0], model_mem[ra[5:0]]);
                end
            endcase
        end

        for (int i = 0; i < REG_DEPTH; i += 7) host_check("final_mem", 6'(i), model_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
